load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit. Consumes the ALU's `ALUResult` as the effective address and drives a word-wide data memory over a request/grant/response handshake. Performs byte-lane steering and byte enables for stores, and lane extraction plus sign/zero extension for loads. Stalls the pipeline for the duration of each access.

## Interface
- `DATA_WIDTH`, 32: data width; only 32 is supported (4 byte lanes).
- `ADDR_WIDTH`, 32: address width.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `LsuValid` in 1: instruction in memory stage is valid; held with operands stable while `LsuStall`=1.
- `MemRead` in 1: load.
- `MemWrite` in 1: store; takes priority if both are set.
- `Funct3` in 3: access size/sign. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `ALUResult` in ADDR_WIDTH: byte address.
- `WriteData` in DATA_WIDTH: store data (rs2).
- `LsuStall` out 1: `LsuValid && (MemRead||MemWrite) && !LsuDone`, combinational.
- `LsuDone` out 1: one-cycle completion pulse.
- `LsuFault` out 1: qualifies `LsuDone`; misaligned access or unsupported Funct3.
- `ReadData` out DATA_WIDTH: extended load result, registered; valid with `LsuDone` on loads and held until the next load completes.
- `MemReq` out 1: memory request.
- `MemWe` out 1: request is a write.
- `MemAddr` out ADDR_WIDTH: word address, bits [1:0] forced to 0.
- `MemBE` out 4: byte enables.
- `MemWData` out 32: lane-steered store data.
- `MemGnt` in 1: request accepted this cycle.
- `MemRValid` in 1: read data valid; at least 1 cycle after grant.
- `MemRData` in 32: read word.

## Operation
- States: IDLE, REQ, RESP, DONE, FAULT.
- Capture registers: address, store data, Funct3, and the op bit (write=1).
- IDLE:
  - `LsuValid && (MemRead||MemWrite)`: capture the registers.
  - If misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) or Funct3 unsupported for the op → FAULT.
  - Otherwise → REQ.
  - Neither MemRead nor MemWrite: stay in IDLE, no stall.
- REQ: `MemReq`=1 with `MemAddr`/`MemWe`/`MemBE`/`MemWData` driven from the capture registers, held stable until `MemGnt`. On `MemGnt`: write → DONE, read → RESP.
- RESP: wait for `MemRValid`. On it, `ReadData` ← extended lane; → DONE. `MemRValid` in any other state is ignored.
- DONE: `LsuDone`=1 → IDLE. This state does not re-capture, even though `LsuValid` is still high.
- FAULT: `LsuDone`=1, `LsuFault`=1, no memory request → IDLE. `ReadData` unchanged.
- Store steering, with o=addr[1:0]:
  - SB: BE = 0001<<o, WData = {4{WriteData[7:0]}}.
  - SH: BE = 0011<<o, WData = {2{WriteData[15:0]}}.
  - SW: BE = 1111, WData = WriteData.
- Load extraction:
  - lane = MemRData >> (8·o).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- `MemBE` = 0000 and `MemWData` = 0 when `MemReq`=0.

## Timing
- Reset (async, immediate):
  - state IDLE.
  - `MemReq`, `MemWe`, `LsuDone`, `LsuFault` = 0.
  - `MemAddr`, `MemBE`, `MemWData`, `ReadData` = 0.
- Reset mid-access: the request is abandoned and `MemReq` drops asynchronously. The memory must tolerate this.
- `MemReq`/`MemWe`/`MemAddr`/`MemBE`/`MemWData`/`LsuDone`/`LsuFault` are decoded from state and registers only; there is no combinational input→output path except `LsuStall`.
- Minimum latency, counted from the accept cycle C:
  - Store with immediate grant: REQ at C+1, `LsuDone` at C+2.
  - Load with grant at C+1 and `MemRValid` at C+2: `LsuDone` and `ReadData` valid at C+3.
  - Fault: `LsuDone`+`LsuFault` at C+1.
- Each grant-wait cycle and each rvalid-wait cycle adds exactly one cycle.
- `LsuStall` is high from C through the cycle before `LsuDone`, and low in the `LsuDone` cycle. The pipeline advances on that edge.
- Back-to-back accesses: the next instruction is accepted in IDLE the cycle after DONE, so there is at most one access per 3 cycles.

## Test plan
- SW: addr 0x100, data 0xDEADBEEF, grant at C+1 → `MemAddr`=0x100, BE=1111, WData=0xDEADBEEF, `MemWe`=1, `LsuDone` at C+2, `LsuStall` high for C..C+1.
- SB: addr 0x103, data 0x000000A5 → BE=1000, WData=0xA5A5A5A5. SH: addr 0x102, data 0x1234 → BE=1100, WData=0x12341234.
- Load with `MemRData`=0x80FF7F01:
  - LB @0x3 → 0xFFFFFF80.
  - LBU @0x3 → 0x00000080.
  - LH @0x2 → 0xFFFF80FF.
  - LHU @0x0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Misalignment: LW @0x102 and SH @0x101 → no `MemReq`, `LsuDone`=`LsuFault`=1 at C+1, `ReadData` unchanged. Funct3=011 load → fault.
- Grant held off 3 cycles, then `MemRValid` 2 cycles after grant → request fields stable throughout, `LsuDone` at C+7. A stray `MemRValid` in IDLE leaves `ReadData` unchanged.
- Assert `rst_n`=0 while in RESP → `MemReq`/`LsuDone`=0 immediately. After release, a fresh SW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-lane steering for stores, lane extract + sign/zero extend for loads.
// Latency: store 2 cycles, load 3 cycles, fault 1 cycle minimum; +1 per grant-wait and per rvalid-wait cycle.
// Backpressure: LsuStall holds the pipeline until LsuDone; MemReq and its fields are held stable until MemGnt.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  LsuValid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [ADDR_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  LsuStall,
    output logic                  LsuDone,
    output logic                  LsuFault,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [3:0]            MemBE,
    output logic [DATA_WIDTH-1:0] MemWData,
    input  logic                  MemGnt,
    input  logic                  MemRValid,
    input  logic [DATA_WIDTH-1:0] MemRData
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, FAULT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [2:0]            cap_f3;
    logic                  cap_we;

    logic                  access;
    logic                  new_we;
    logic                  bad_f3;
    logic                  misaligned;
    logic [3:0]            be_raw;
    logic [DATA_WIDTH-1:0] wd_raw;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_ext;

    assign access = LsuValid && (MemRead || MemWrite);
    assign new_we = MemWrite;

    // Outputs toward memory and pipeline decode only from state and capture registers,
    // so reset drops MemReq immediately and nothing combinational leaks from inputs.
    assign MemReq   = (state == REQ);
    assign MemWe    = MemReq && cap_we;
    assign MemAddr  = {cap_addr[ADDR_WIDTH-1:2], 2'b00};
    assign MemBE    = MemReq ? be_raw : 4'b0000;
    assign MemWData = MemReq ? wd_raw : '0;
    assign LsuDone  = (state == DONE) || (state == FAULT);
    assign LsuFault = (state == FAULT);
    assign LsuStall = access && !LsuDone;

    // Legality of the incoming access: unsupported size/sign code or misaligned address.
    always_comb begin
        bad_f3     = 1'b0;
        misaligned = 1'b0;
        if (new_we) begin
            bad_f3 = (Funct3[2] == 1'b1) || (Funct3[1:0] == 2'b11);
        end else begin
            bad_f3 = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
        end
        if (Funct3[1:0] == 2'b01) begin
            misaligned = ALUResult[0];
        end else if (Funct3[1:0] == 2'b10) begin
            misaligned = (ALUResult[1:0] != 2'b00);
        end
    end

    // Byte enables and replicated write data; the lane selected by BE picks the right copy.
    always_comb begin
        be_raw = 4'b0000;
        wd_raw = '0;
        case (cap_f3[1:0])
            2'b00: begin
                be_raw = 4'b0001 << cap_addr[1:0];
                wd_raw = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                be_raw = 4'b0011 << cap_addr[1:0];
                wd_raw = {2{cap_wdata[15:0]}};
            end
            2'b10: begin
                be_raw = 4'b1111;
                wd_raw = cap_wdata;
            end
            default: begin
                be_raw = 4'b0000;
                wd_raw = '0;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend according to the load type.
    always_comb begin
        lane     = MemRData >> {cap_addr[1:0], 3'b000};
        load_ext = lane;
        case (cap_f3)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Access sequencer: capture in IDLE, hold request until grant, wait for read data, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_f3    <= 3'b000;
            cap_we    <= 1'b0;
            ReadData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        cap_addr  <= ALUResult;
                        cap_wdata <= WriteData;
                        cap_f3    <= Funct3;
                        cap_we    <= new_we;
                        state     <= (bad_f3 || misaligned) ? FAULT : REQ;
                    end
                end
                REQ: begin
                    if (MemGnt) begin
                        state <= cap_we ? DONE : RESP;
                    end
                end
                RESP: begin
                    if (MemRValid) begin
                        ReadData <= load_ext;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of accesses plus reset and idle corner sequences.
// Latency: each vector is driven at a negedge and followed cycle by cycle until LsuDone (bounded).
// Backpressure: the bench plays the memory, delaying MemGnt and MemRValid per vector.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        LsuValid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic        LsuStall, LsuDone, LsuFault;
    logic [31:0] ReadData;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBE;
    logic [31:0] MemWData;
    logic        MemGnt, MemRValid;
    logic [31:0] MemRData;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_rd;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .LsuValid(LsuValid), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData), .LsuStall(LsuStall),
        .LsuDone(LsuDone), .LsuFault(LsuFault), .ReadData(ReadData), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemBE(MemBE), .MemWData(MemWData), .MemGnt(MemGnt),
        .MemRValid(MemRValid), .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gw;
        int          rw;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdexp;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gw, input int rw,
                                input logic fault, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] rdexp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gw = gw; v.rw = rw; v.fault = fault; v.be = be; v.wd = wd; v.rdexp = rdexp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        LsuValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = '0; WriteData = '0; MemGnt = 1'b0; MemRValid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          done_cyc, gnt_cyc, req_cnt, exp_lat;
        logic        seen_req, unstable, stall_bad, flt;
        logic [31:0] r_addr, r_wd, rd_at_done;
        logic [3:0]  r_be;
        logic        r_we;
        done_cyc = -1; gnt_cyc = -1; req_cnt = 0;
        seen_req = 1'b0; unstable = 1'b0; stall_bad = 1'b0; flt = 1'b0;
        r_addr = '0; r_wd = '0; r_be = '0; r_we = 1'b0; rd_at_done = '0;

        @(negedge clk);
        LsuValid = 1'b1; MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
        ALUResult = v.addr; WriteData = v.wdata; MemRData = v.rdata;
        #1;
        if (LsuStall !== 1'b1) stall_bad = 1'b1;

        for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            MemGnt = 1'b0; MemRValid = 1'b0;
            if (LsuDone) begin
                done_cyc   = cyc;
                flt        = LsuFault;
                rd_at_done = ReadData;
                if (LsuStall !== 1'b0) stall_bad = 1'b1;
            end else if (LsuStall !== 1'b1) begin
                stall_bad = 1'b1;
            end
            if (MemReq) begin
                if (seen_req && (MemAddr !== r_addr || MemBE !== r_be ||
                                 MemWData !== r_wd || MemWe !== r_we))
                    unstable = 1'b1;
                seen_req = 1'b1;
                r_addr = MemAddr; r_be = MemBE; r_wd = MemWData; r_we = MemWe;
                if (req_cnt == v.gw) begin
                    MemGnt  = 1'b1;
                    gnt_cyc = cyc;
                end
                req_cnt++;
            end
            if (!v.wr && gnt_cyc >= 0 && cyc == gnt_cyc + 1 + v.rw) MemRValid = 1'b1;
        end
        idle_inputs();

        exp_lat = v.fault ? 1 : (v.wr ? 2 + v.gw : 3 + v.gw + v.rw);
        if (!(v.rd && !v.wr && !v.fault)) begin
            // stores and faults leave the load result untouched
        end else begin
            model_rd = v.rdexp;
        end
        check($sformatf("v%0d_done_cycle", idx), done_cyc, exp_lat);
        check($sformatf("v%0d_fault", idx), {31'd0, flt}, {31'd0, v.fault});
        check($sformatf("v%0d_req_seen", idx), {31'd0, seen_req}, {31'd0, !v.fault});
        check($sformatf("v%0d_stall", idx), {31'd0, stall_bad}, 32'd0);
        check($sformatf("v%0d_readdata", idx), rd_at_done, model_rd);
        if (!v.fault) begin
            check($sformatf("v%0d_addr", idx), r_addr, {v.addr[31:2], 2'b00});
            check($sformatf("v%0d_we", idx), {31'd0, r_we}, {31'd0, v.wr});
            check($sformatf("v%0d_stable", idx), {31'd0, unstable}, 32'd0);
            if (v.wr) begin
                check($sformatf("v%0d_be", idx), {28'd0, r_be}, {28'd0, v.be});
                check($sformatf("v%0d_wdata", idx), r_wd, v.wd);
            end
        end
    endtask

    initial begin
        int got_req, got_done, got_stall;

        vt[0]  = mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
        vt[1]  = mk(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0);
        vt[2]  = mk(0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, 0, 0, 4'b1100, 32'h12341234, 32'h0);
        vt[3]  = mk(0, 1, 3'b000, 32'h101, 32'hFFFFFF3C, 32'h0, 0, 0, 0, 4'b0010, 32'h3C3C3C3C, 32'h0);
        vt[4]  = mk(1, 0, 3'b000, 32'h3,   32'h0, 32'h80FF7F01, 0, 0, 0, 4'h0, 32'h0, 32'hFFFFFF80);
        vt[5]  = mk(1, 0, 3'b100, 32'h3,   32'h0, 32'h80FF7F01, 0, 0, 0, 4'h0, 32'h0, 32'h00000080);
        vt[6]  = mk(1, 0, 3'b001, 32'h2,   32'h0, 32'h80FF7F01, 0, 0, 0, 4'h0, 32'h0, 32'hFFFF80FF);
        vt[7]  = mk(1, 0, 3'b101, 32'h0,   32'h0, 32'h80FF7F01, 0, 0, 0, 4'h0, 32'h0, 32'h00007F01);
        vt[8]  = mk(1, 0, 3'b010, 32'h0,   32'h0, 32'h80FF7F01, 0, 0, 0, 4'h0, 32'h0, 32'h80FF7F01);
        vt[9]  = mk(1, 0, 3'b000, 32'h1,   32'h0, 32'h80FF7F01, 0, 0, 0, 4'h0, 32'h0, 32'h0000007F);
        vt[10] = mk(1, 0, 3'b010, 32'h102, 32'h0, 32'h11111111, 0, 0, 1, 4'h0, 32'h0, 32'h0);
        vt[11] = mk(0, 1, 3'b001, 32'h101, 32'h5555, 32'h0,     0, 0, 1, 4'h0, 32'h0, 32'h0);
        vt[12] = mk(1, 0, 3'b011, 32'h0,   32'h0, 32'h22222222, 0, 0, 1, 4'h0, 32'h0, 32'h0);
        vt[13] = mk(0, 1, 3'b100, 32'h0,   32'h77, 32'h0,       0, 0, 1, 4'h0, 32'h0, 32'h0);
        vt[14] = mk(1, 0, 3'b010, 32'h40,  32'h0, 32'hCAFEF00D, 3, 1, 0, 4'h0, 32'h0, 32'hCAFEF00D);
        vt[15] = mk(1, 1, 3'b010, 32'h200, 32'h11223344, 32'h0, 1, 0, 0, 4'b1111, 32'h11223344, 32'h0);
        vt[16] = mk(1, 0, 3'b001, 32'h2,   32'h0, 32'h7FFF0000, 0, 2, 0, 4'h0, 32'h0, 32'h00007FFF);

        idle_inputs();
        MemRData = '0;
        rst_n    = 1'b0;
        model_rd = '0;
        repeat (2) @(negedge clk);
        check("rst_memreq", {31'd0, MemReq}, 32'd0);
        check("rst_done", {31'd0, LsuDone}, 32'd0);
        check("rst_fault", {31'd0, LsuFault}, 32'd0);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_be", {28'd0, MemBE}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // table of single accesses
        for (int i = 0; i < 17; i++) run_vec(i, vt[i]);

        // valid instruction that is neither load nor store: no stall, no request, no done
        @(negedge clk);
        LsuValid = 1'b1;
        got_req = 0; got_done = 0; got_stall = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (LsuStall) got_stall++;
            @(negedge clk);
            if (MemReq) got_req++;
            if (LsuDone) got_done++;
        end
        check("noop_stall", got_stall, 0);
        check("noop_req", got_req, 0);
        check("noop_done", got_done, 0);
        idle_inputs();

        // stray read data while idle must not disturb the load result
        MemRData  = 32'h12345678;
        MemRValid = 1'b1;
        @(negedge clk);
        MemRValid = 1'b0;
        @(negedge clk);
        check("stray_rvalid_readdata", ReadData, model_rd);

        // reset while waiting for read data
        LsuValid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h80; MemRData = 32'hAAAA5555;
        @(negedge clk);
        check("rresp_req_up", {31'd0, MemReq}, 32'd1);
        MemGnt = 1'b1;
        @(negedge clk);
        MemGnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rresp_memreq", {31'd0, MemReq}, 32'd0);
        check("rresp_done", {31'd0, LsuDone}, 32'd0);
        check("rresp_readdata", ReadData, 32'd0);
        model_rd = '0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // reset while a request is outstanding drops it without waiting for a clock
        @(negedge clk);
        LsuValid = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h300; WriteData = 32'h0BADF00D;
        @(negedge clk);
        check("rreq_req_up", {31'd0, MemReq}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rreq_memreq", {31'd0, MemReq}, 32'd0);
        check("rreq_be", {28'd0, MemBE}, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // a fresh store after reset completes normally
        run_vec(100, vt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
